layer_boundary_skid_stage: RTL and testbench

- Registered pipeline stage between two LUT-neuron layers: captures the concatenated 2-bit neuron outputs of layer N and presents them to the fan-in wiring of layer N+1.
- Two-entry skid buffer with valid/ready on both sides; downstream back-pressure never drops or duplicates a vector.
- Breaks the combinational path through consecutive distributed-ROM layers at full throughput (one vector per cycle).

---
 rtl/layer_boundary_skid_stage.sv | 147 ++++++++++++++
 tb/tb_layer_boundary_skid_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer_boundary_skid_stage.sv
// layer_boundary_skid_stage
// Registered two-entry skid buffer between two LUT-neuron layers. It carries
// a vector of NEURONS x OUT_BITS activations unchanged, keeps strict FIFO
// order, and sustains one vector per cycle when the downstream side is ready.
//
// Handshake: a beat moves on an edge where valid and ready are both high.
// s_ready is registered and depends only on stage state, never on s_valid.
// m_valid/m_data hold steady while m_valid=1 and m_ready=0.
//
// The FSM state is visible on the occupancy output (EMPTY=0, ONE=1, FULL=2).
//
// Optional build macro: LAYER_SKID_STATS_EN adds the saturating
// xfer_count and stall_count outputs.
module layer_boundary_skid_stage #(
  parameter int NEURONS  = 16,
  parameter int OUT_BITS = 2,
  parameter int DATA_W   = NEURONS * OUT_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        occupancy
`ifdef LAYER_SKID_STATS_EN
  ,
  output logic [31:0]       xfer_count,
  output logic [31:0]       stall_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              s_ready_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  logic accept;
  logic consume;
  logic load_main_from_in;
  logic load_main_from_skid;
  logic load_skid;

  assign accept    = s_valid & s_ready_q;
  assign consume   = m_valid & m_ready;

  assign s_ready   = s_ready_q;
  assign m_valid   = (state_q != EMPTY);
  assign m_data    = main_q;
  assign occupancy = state_q;

  // Next-state and register-load selection for the two storage entries.
  always_comb begin
    state_d             = state_q;
    load_main_from_in   = 1'b0;
    load_main_from_skid = 1'b0;
    load_skid           = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          load_main_from_in = 1'b1;
          state_d           = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          // New vector replaces the departing one on the same edge.
          load_main_from_in = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // s_ready is low here, so only the consume path matters.
        if (consume) begin
          load_main_from_skid = 1'b1;
          state_d             = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State and registered s_ready; reset holds s_ready low, flush empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      s_ready_q <= 1'b0;
    end else if (flush) begin
      state_q   <= EMPTY;
      s_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d != FULL);
    end
  end

  // Data entries; flush leaves contents alone since m_valid drops anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      if (load_main_from_in) begin
        main_q <= s_data;
      end else if (load_main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= s_data;
      end
    end
  end

`ifdef LAYER_SKID_STATS_EN
  // Saturating transfer and stall counters, cleared by rst or flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      xfer_count  <= '0;
      stall_count <= '0;
    end else begin
      if (consume && (xfer_count != 32'hFFFF_FFFF)) begin
        xfer_count <= xfer_count + 32'd1;
      end
      if (m_valid && !m_ready && (stall_count != 32'hFFFF_FFFF)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_layer_boundary_skid_stage.sv
// Bench for layer_boundary_skid_stage: reset, streaming, a directed vector
// table for back-pressure/flush/replace, random stalls with a scoreboard,
// and the optional statistics counters when LAYER_SKID_STATS_EN is defined.
module tb_layer_boundary_skid_stage;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic [1:0]   occupancy;
`ifdef LAYER_SKID_STATS_EN
  logic [31:0]  xfer_count;
  logic [31:0]  stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  layer_boundary_skid_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy)
`ifdef LAYER_SKID_STATS_EN
    ,
    .xfer_count  (xfer_count),
    .stall_count (stall_count)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         sv;
    logic [W-1:0] d;
    logic         mr;
    logic         fl;
    logic         ev;
    logic [W-1:0] ed;
    logic         esr;
    logic [1:0]   eocc;
  } vec_t;

  vec_t tbl[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [W-1:0] d, input logic mr, input logic fl);
    s_valid = sv;
    s_data  = d;
    m_ready = mr;
    flush   = fl;
  endtask

  initial begin
    logic [W-1:0] held_data;
    logic         stalled;
    logic         acc;
    logic         con;
    logic [W-1:0] payload;
    logic [W-1:0] exp_v;
    int           budget;

    rst = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Reset: three cycles with a valid vector presented.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_m_valid", W'(m_valid), W'(1'b0));
      check("rst_m_data", m_data, '0);
      check("rst_s_ready", W'(s_ready), W'(1'b0));
      check("rst_occ", W'(occupancy), W'(2'd0));
    end
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    check("rel_s_ready", W'(s_ready), W'(1'b1));
    check("rel_m_valid", W'(m_valid), W'(1'b0));

    // Streaming: 100 vectors back to back with m_ready high.
    for (int i = 1; i <= 100; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0);
      step();
      check("stream_data", m_data, W'(i));
      check("stream_valid", W'(m_valid), W'(1'b1));
      check("stream_occ", W'(occupancy), W'(2'd1));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check("stream_drain_valid", W'(m_valid), W'(1'b0));

    // Directed table: back-pressure, flush with same-cycle push, replace in ONE.
    tbl[0]  = '{1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 2'd1};
    tbl[1]  = '{1'b1, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 2'd2};
    tbl[2]  = '{1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 2'd2};
    tbl[3]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h5A5A5A5A, 1'b1, 2'd1};
    tbl[4]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 2'd0};
    tbl[5]  = '{1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 2'd1};
    tbl[6]  = '{1'b1, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 2'd2};
    tbl[7]  = '{1'b1, 32'h11111111, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b1, 2'd0};
    tbl[8]  = '{1'b1, 32'h22222222, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b1, 2'd1};
    tbl[9]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 2'd0};
    tbl[10] = '{1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 2'd1};
    tbl[11] = '{1'b1, 32'h0BADBEEF, 1'b1, 1'b0, 1'b1, 32'h0BADBEEF, 1'b1, 2'd1};
    tbl[12] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 2'd0};

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].sv, tbl[i].d, tbl[i].mr, tbl[i].fl);
      step();
      check($sformatf("tbl%0d_m_valid", i), W'(m_valid), W'(tbl[i].ev));
      check($sformatf("tbl%0d_s_ready", i), W'(s_ready), W'(tbl[i].esr));
      check($sformatf("tbl%0d_occ", i), W'(occupancy), W'(tbl[i].eocc));
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d_m_data", i), m_data, tbl[i].ed);
      end
    end

    // Random stalls with an incrementing payload and scoreboard.
    payload = 32'h1000_0000;
    stalled = 1'b0;
    held_data = '0;
    for (int c = 0; c < 10000; c++) begin
      if (stalled) begin
        check("stall_valid_held", W'(m_valid), W'(1'b1));
        check("stall_data_held", m_data, held_data);
      end
      drive(1'($urandom_range(0, 1)), payload, 1'($urandom_range(0, 1)), 1'b0);
      acc = s_valid && s_ready;
      con = m_valid && m_ready;
      if (con) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_out", m_data, 'x);
        end else begin
          exp_v = exp_q.pop_front();
          check("rand_order", m_data, exp_v);
        end
      end
      if (acc) begin
        exp_q.push_back(payload);
        payload = payload + 1;
      end
      stalled   = m_valid && !m_ready;
      held_data = m_data;
      step();
    end

    // Drain remaining entries, bounded.
    budget = 0;
    drive(1'b0, '0, 1'b1, 1'b0);
    while (exp_q.size() != 0 && budget < 10) begin
      if (m_valid) begin
        exp_v = exp_q.pop_front();
        check("drain_order", m_data, exp_v);
      end
      step();
      budget++;
    end
    check("drain_left", W'(exp_q.size()), '0);
    check("drain_empty_valid", W'(m_valid), W'(1'b0));

`ifdef LAYER_SKID_STATS_EN
    // Statistics: 5 transfers, then 7 stall cycles, then reset.
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, W'(i + 1), 1'b1, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check("stats_xfer5", xfer_count, 32'd5);
    drive(1'b1, 32'h77, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step();
    end
    check("stats_stall7", stall_count, 32'd7);
    check("stats_xfer_still5", xfer_count, 32'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("stats_xfer_rst", xfer_count, 32'd0);
    check("stats_stall_rst", stall_count, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
